// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and baud divisor helper.
// Used by both the transmitter and the decoder.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS = 10;

   // Integer truncation, so the real baud rate is slightly above the nominal one.
   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/subservient_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate counter.
module subservient_uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [7:0]                 i_din,
   output logic [7:0]                 o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
      $error("subservient_uart_tx_fifo: DEPTH must be a power of two and >= 2");
   end

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_push;
   logic        w_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_level = r_wptr - r_rptr;
   assign o_dout  = r_mem[r_rptr[AW-1:0]];

   // Qualified on the pre-edge flags: a push while full is dropped even if a pop frees a slot.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/subservient_uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a valid/ready byte FIFO.
// The line idles high and frames are sent back to back while the FIFO holds data.
module subservient_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100000000,
   parameter int unsigned BAUD_RATE   = 57600,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst_n,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("subservient_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
   end

   uart_state_t       r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_tx;

   logic       w_full;
   logic       w_empty;
   logic [7:0] w_dout;
   logic       w_baud_last;
   logic       w_pop;

   subservient_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .wb_clk   (wb_clk),
      .wb_rst_n (wb_rst_n),
      .i_push   (i_valid),
      .i_pop    (w_pop),
      .i_din    (i_data),
      .o_dout   (w_dout),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (o_level)
   );

   assign w_baud_last = (r_baud == BAUD_LAST);
   assign w_pop       = !w_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));

   assign o_ready = !w_full;
   assign o_tx    = r_tx;
   assign o_busy  = (r_state != IDLE) || !w_empty;

   // o_tx follows the state one cycle later, so the start bit begins two edges after a push.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               if (!w_empty) begin
                  r_shift <= w_dout;
                  r_state <= START;
               end
            end
            START: begin
               r_tx <= 1'b0;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               r_tx <= r_shift[0];
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == BIT_LAST) begin
                     r_state <= STOP;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP: begin
               r_tx <= 1'b1;
               if (w_baud_last) begin
                  r_baud <= '0;
                  if (!w_empty) begin
                     r_shift <= w_dout;
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subservient_uart_tx.sv
// Bench for subservient_uart_tx: cycle-level reference model plus a line decoder
// that pops expected bytes from a scoreboard queue.
module tb_subservient_uart_tx;

   localparam int unsigned CLK_HZ = 1000000;
   localparam int unsigned BAUD   = 100000;
   localparam int unsigned DEPTH  = 4;
   localparam int          CPB    = 10;
   localparam int          FRAME  = 10 * CPB;

   logic       wb_clk = 1'b0;
   logic       wb_rst_n = 1'b0;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;
   logic       o_tx;
   logic       o_busy;
   logic [2:0] o_level;

   subservient_uart_tx #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .wb_clk   (wb_clk),
      .wb_rst_n (wb_rst_n),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_tx     (o_tx),
      .o_busy   (o_busy),
      .o_level  (o_level)
   );

   always #5 wb_clk = ~wb_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: FIFO contents, time of the last pop, byte on the line.
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         last_pop = 0;
   bit         has_popped = 0;
   logic [7:0] cur_byte = '0;
   bit         chk_en = 0;
   int         accepted = 0;
   int         max_level = 0;

   always @(posedge wb_clk) begin
      logic full_pre, empty_pre;
      logic [5:0] exp_v;
      logic       e_tx;
      int         off, bitn, lvl;
      cyc++;
      if (wb_rst_n && chk_en) begin
         full_pre  = (mq.size() == DEPTH);
         empty_pre = (mq.size() == 0);
         if (!empty_pre && (!has_popped || cyc >= last_pop + FRAME)) begin
            cur_byte   = mq.pop_front();
            last_pop   = cyc;
            has_popped = 1;
         end
         if (i_valid && !full_pre) begin
            mq.push_back(i_data);
            exp_q.push_back(i_data);
            accepted++;
         end
      end
      #1;
      if (wb_rst_n && chk_en) begin
         lvl  = mq.size();
         e_tx = 1'b1;
         if (has_popped && cyc >= last_pop + 1 && cyc <= last_pop + FRAME) begin
            off  = cyc - last_pop - 1;
            bitn = off / CPB;
            if (bitn == 0) e_tx = 1'b0;
            else if (bitn <= 8) e_tx = cur_byte[bitn-1];
         end
         exp_v = {e_tx, lvl < DEPTH, (has_popped && cyc < last_pop + FRAME) || lvl != 0,
                  3'(lvl)};
         check("cycle{tx,ready,busy,level}", {o_tx, o_ready, o_busy, o_level}, exp_v);
         if (int'(o_level) > max_level) max_level = o_level;
      end
   end

   // Line decoder: samples mid-bit on the falling clock edge.
   bit         rx_active = 0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte;
   int         frames_rx = 0;

   always @(negedge wb_clk) begin
      if (!wb_rst_n) begin
         rx_active = 0;
      end else if (!rx_active) begin
         if (o_tx == 1'b0) begin
            rx_active = 1;
            rx_cnt    = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 5) check("rx_start_bit", o_tx, 0);
         if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
            rx_byte[(rx_cnt - 15) / 10] = o_tx;
         if (rx_cnt == 95) begin
            check("rx_stop_bit", o_tx, 1);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rx_unexpected: got byte %0h, expected no frame", rx_byte);
            end else begin
               check("rx_byte", rx_byte, exp_q.pop_front());
            end
            frames_rx++;
            rx_active = 0;
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge wb_clk);
      i_valid = v;
      i_data  = d;
   endtask

   task automatic push_one(input logic [7:0] d);
      int t = 0;
      @(negedge wb_clk);
      while (!o_ready && t < 3000) begin
         @(negedge wb_clk);
         t++;
      end
      check("ready_wait", o_ready, 1);
      i_valid = 1'b1;
      i_data  = d;
      @(negedge wb_clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge wb_clk);
      while ((o_busy || o_level != 0) && t < 5000) begin
         @(negedge wb_clk);
         t++;
      end
      check("drained_busy", o_busy, 0);
      repeat (5) @(negedge wb_clk);
   endtask

   task automatic reset_model();
      mq.delete();
      exp_q.delete();
      has_popped = 0;
   endtask

   initial begin
      int f0, a0;
      i_valid = 1'b0;
      i_data  = 8'h00;
      #12;
      check("rst_tx", o_tx, 1);
      check("rst_ready", o_ready, 1);
      check("rst_busy", o_busy, 0);
      check("rst_level", o_level, 0);
      repeat (2) @(negedge wb_clk);
      wb_rst_n = 1'b1;
      chk_en   = 1;

      // Idle line
      repeat (1000) @(negedge wb_clk);
      check("idle_tx", o_tx, 1);
      check("idle_busy", o_busy, 0);

      // Single byte
      f0 = frames_rx;
      drive(1'b1, 8'h55);
      drive(1'b0, 8'h00);
      wait_idle();
      check("single_frames", frames_rx - f0, 1);

      // Back-to-back
      f0 = frames_rx;
      drive(1'b1, 8'hA5);
      drive(1'b1, 8'h3C);
      drive(1'b0, 8'h00);
      wait_idle();
      check("b2b_frames", frames_rx - f0, 2);

      // FIFO full: 6 held pushes, sixth rejected
      f0 = frames_rx;
      max_level = 0;
      for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
      drive(1'b0, 8'h00);
      wait_idle();
      check("full_frames", frames_rx - f0, 5);
      check("full_max_level", max_level, 4);

      // Pointer wrap
      f0 = frames_rx;
      for (int i = 0; i < 9; i++) push_one(8'($urandom));
      wait_idle();
      check("wrap_frames", frames_rx - f0, 9);
      check("wrap_level", o_level, 0);

      // Random traffic
      f0 = frames_rx;
      a0 = accepted;
      for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 3) == 0), 8'($urandom));
      drive(1'b0, 8'h00);
      wait_idle();
      check("rand_frames", frames_rx - f0, accepted - a0);

      // Reset during data bit 3 of 0xFF
      drive(1'b1, 8'hFF);
      drive(1'b0, 8'h00);
      repeat (45) @(negedge wb_clk);
      f0 = frames_rx;
      #2;
      chk_en   = 0;
      wb_rst_n = 1'b0;
      reset_model();
      #1;
      check("midrst_tx", o_tx, 1);
      check("midrst_level", o_level, 0);
      check("midrst_busy", o_busy, 0);
      repeat (2) @(negedge wb_clk);
      wb_rst_n = 1'b1;
      chk_en   = 1;
      repeat (200) @(negedge wb_clk);
      check("midrst_no_frames", frames_rx - f0, 0);
      drive(1'b1, 8'h81);
      drive(1'b0, 8'h00);
      wait_idle();
      check("post_rst_frames", frames_rx - f0, 1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
